// File: rtl/pixie_video_back_end.sv
// pixie_video_back_end
//   Read side of the Pixie frame buffer. Keeps its own raster counters, fetches
//   one byte per 8 active pixels from the 128x8-byte buffer, and shifts each
//   byte out MSB first as 1-bit video. Also generates the sync and blank signals.
//
// Ports
//   clk, reset       system clock, async active-high reset
//   clk_enable       pixel enable (never high on two consecutive clocks)
//   disp_enable      display on/off, sampled only at frame start
//   rd_data          frame buffer data, valid 1 clk after rd_en
//   rd_addr, rd_en   frame buffer read port (rd_en is a one-clk strobe)
//   video            pixel out, 1 = lit
//   hsync, vsync     active-high syncs
//   hblank, vblank   high outside the active columns / lines
module pixie_video_back_end #(
  parameter int H_TOTAL        = 112,
  parameter int H_ACTIVE_START = 8,
  parameter int HSYNC_START    = 88,
  parameter int HSYNC_LEN      = 8,
  parameter int V_TOTAL        = 262,
  parameter int V_ACTIVE_START = 80,
  parameter int VSYNC_START    = 230,
  parameter int VSYNC_LEN      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       disp_enable,
  input  logic [7:0] rd_data,
  output logic [9:0] rd_addr,
  output logic       rd_en,
  output logic       video,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank
);

  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int ACT_PIX   = 64;
  localparam int ACT_LINES = 128;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          frame_en;
  logic          primed;      // first frame start after reset has passed
  logic          fetch_pend;  // read issued last clk, data arrives now
  logic [7:0]    fetch_buf;
  logic [7:0]    shifter;
  logic [7:0]    shifter_nxt;
  logic [9:0]    addr_q;

  // One extra bit on the positions so window ends never overflow the compare.
  logic [HW:0]   hx, h_rel, h_frel;
  logic [VW:0]   vx, v_rel;
  logic          line_act, col_act, load, fetch_col, fetch;
  logic          h_wrap, v_wrap, hsync_nxt, vsync_nxt;
  logic [6:0]    row;

  assign hx     = {1'b0, h_count};
  assign vx     = {1'b0, v_count};
  assign h_rel  = hx - (HW+1)'(H_ACTIVE_START);
  assign h_frel = hx - (HW+1)'(H_ACTIVE_START - 1);
  assign v_rel  = vx - (VW+1)'(V_ACTIVE_START);
  assign row    = v_rel[6:0];

  assign line_act  = (vx >= (VW+1)'(V_ACTIVE_START)) && (v_rel < (VW+1)'(ACT_LINES));
  assign col_act   = (hx >= (HW+1)'(H_ACTIVE_START)) && (h_rel < (HW+1)'(ACT_PIX));
  assign load      = col_act && (h_rel[2:0] == 3'd0);
  // Fetch one enable ahead of each byte boundary so the byte is in fetch_buf
  // by the time the shifter loads it.
  assign fetch_col = (hx >= (HW+1)'(H_ACTIVE_START - 1)) && (h_frel < (HW+1)'(ACT_PIX))
                     && (h_frel[2:0] == 3'd0);
  assign fetch     = clk_enable && frame_en && line_act && fetch_col;

  assign hsync_nxt = (hx >= (HW+1)'(HSYNC_START)) && (hx < (HW+1)'(HSYNC_START + HSYNC_LEN));
  assign vsync_nxt = (vx >= (VW+1)'(VSYNC_START)) && (vx < (VW+1)'(VSYNC_START + VSYNC_LEN));

  assign h_wrap = (h_count == HW'(H_TOTAL - 1));
  assign v_wrap = (v_count == VW'(V_TOTAL - 1));

  // Address is presented during the strobe clk; otherwise the last one holds.
  assign rd_en   = fetch;
  assign rd_addr = fetch ? {row, h_frel[5:3]} : addr_q;

  // At a byte boundary the new byte's MSB goes straight to video.
  assign shifter_nxt = load ? fetch_buf : {shifter[6:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count    <= '0;
      v_count    <= '0;
      frame_en   <= 1'b0;
      primed     <= 1'b0;
      fetch_pend <= 1'b0;
      fetch_buf  <= '0;
      shifter    <= '0;
      addr_q     <= '0;
      video      <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      hblank     <= 1'b0;
      vblank     <= 1'b0;
    end else begin
      fetch_pend <= fetch;
      if (fetch_pend) fetch_buf <= rd_data;
      if (fetch)      addr_q    <= rd_addr;
      if (clk_enable) begin
        h_count <= h_wrap ? '0 : h_count + 1'b1;
        if (h_wrap) v_count <= v_wrap ? '0 : v_count + 1'b1;
        // The frame that starts right out of reset stays blank.
        if (h_count == '0 && v_count == '0) begin
          primed <= 1'b1;
          if (primed) frame_en <= disp_enable;
        end
        shifter <= shifter_nxt;
        hblank  <= !col_act;
        vblank  <= !line_act;
        hsync   <= hsync_nxt;
        vsync   <= vsync_nxt;
        video   <= line_act && col_act && frame_en && shifter_nxt[7];
      end
    end
  end

endmodule

// File: tb/tb_pixie_video_back_end.sv
// Bench for pixie_video_back_end with a shortened raster so several frames fit
// in the run. A behavioural raster model predicts every output; a few literal
// expectations pin the model to hand-derived values.
module tb_pixie_video_back_end;
  localparam int HT = 68, HA = 1, HS = 65, HL = 2;
  localparam int VT = 131, VA = 1, VS = 129, VL = 2;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0, reset = 1'b1, clk_enable = 1'b0, disp_enable = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [9:0] rd_addr;
  logic       rd_en, video, hsync, vsync, hblank, vblank;
  logic [7:0] mem [0:1023];

  int vectors = 0, miscompares = 0;

  pixie_video_back_end #(
    .H_TOTAL(HT), .H_ACTIVE_START(HA), .HSYNC_START(HS), .HSYNC_LEN(HL),
    .V_TOTAL(VT), .V_ACTIVE_START(VA), .VSYNC_START(VS), .VSYNC_LEN(VL)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .disp_enable(disp_enable),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_en(rd_en), .video(video),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
  );

  always #5 clk = ~clk;

  // Synchronous frame buffer read port.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit line_on(int v); return v >= VA && v < VA + 128; endfunction
  function automatic bit col_on(int h);  return h >= HA && h < HA + 64;  endfunction
  function automatic bit fetch_at(int h, int v, bit fe);
    return fe && line_on(v) && h >= HA - 1 && h < HA - 1 + 64 && ((h - (HA - 1)) % 8) == 0;
  endfunction
  function automatic bit pixel(int v, int h);
    logic [7:0] b;
    b = mem[(v - VA) * 8 + (h - HA) / 8];
    return b[7 - (h - HA) % 8];
  endfunction

  // ---------------- behavioural model ----------------
  int mh, mv, fidx, m_addr, last_h, last_v, last_f;
  bit mfe, seen_start;
  bit e_video, e_hs, e_vs, e_hb, e_vb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh = 0; mv = 0; fidx = 0; m_addr = 0; mfe = 0; seen_start = 0;
      last_h = -1; last_v = -1; last_f = -1;
      e_video = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    end else if (clk_enable) begin
      if (mh == 0 && mv == 0) begin
        if (seen_start) mfe = disp_enable;
        seen_start = 1;
      end
      e_hb    = !col_on(mh);
      e_vb    = !line_on(mv);
      e_hs    = mh >= HS && mh < HS + HL;
      e_vs    = mv >= VS && mv < VS + VL;
      e_video = (mfe && line_on(mv) && col_on(mh)) ? pixel(mv, mh) : 1'b0;
      if (fetch_at(mh, mv, mfe)) m_addr = (mv - VA) * 8 + (mh - HA + 1) / 8;
      last_h = mh; last_v = mv; last_f = fidx;
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0; mv = mv + 1;
        if (mv == VT) begin mv = 0; fidx = fidx + 1; end
      end
    end
  end

  // ---------------- compare + observation ----------------
  int rd_cnt [4];
  int last_addr1, edge_fetch;
  bit line_vid [HT], line_hs [HT], line_hb [HT], vs_line [VT];

  always @(negedge clk) begin
    bit xr;
    int xa;
    xr = clk_enable && fetch_at(mh, mv, mfe);
    xa = xr ? (mv - VA) * 8 + (mh - HA + 1) / 8 : m_addr;
    chk("rd_en", rd_en, xr);
    chk("rd_addr", rd_addr, xa);
    chk("video", video, e_video);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("hblank", hblank, e_hb);
    chk("vblank", vblank, e_vb);
    if (reset) begin
      for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
      last_addr1 = -1; edge_fetch = 0;
    end else begin
      if (rd_en && fidx < 4) begin
        rd_cnt[fidx]++;
        if (fidx == 1) last_addr1 = rd_addr;
        if (mv == VA - 1 || mv == VA + 128) edge_fetch++;
      end
      if (last_f == 1 && last_v == VA && last_h >= 0) begin
        line_vid[last_h] = video; line_hs[last_h] = hsync; line_hb[last_h] = hblank;
      end
      if (last_f == 1 && last_h == 0) vs_line[last_v] = vsync;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 clk_enable = 1'b1;
      @(posedge clk); #1 clk_enable = 1'b0;
      if ($urandom_range(0, 15) == 0) @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0] b;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    disp_enable = 1'b1;

    // Frame out of reset is blank; the next one displays. Break in mid-line.
    run_en(FRAME);
    run_en(40 * HT + 20);
    chk("pre_reset_vblank", vblank, 0);
    chk("pre_reset_fetches", rd_cnt[1], 315);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("async_reset", {video, hsync, vsync, hblank, vblank, rd_en, rd_addr}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_en(FRAME);                      // frame 0: blank after reset
    run_en((VA + 40) * HT);             // frame 1: displayed
    disp_enable = 1'b0;                 // drop mid-frame: frame 1 unaffected
    run_en(FRAME - (VA + 40) * HT);
    run_en(50 * HT);                    // frame 2: blank
    disp_enable = 1'b1;
    run_en(FRAME - 50 * HT);
    run_en(10 * HT);                    // frame 3: resumed, lines 0..9

    b = 8'h00;
    for (int j = 0; j < 8; j++) b = {b[6:0], line_vid[HA + j]};
    chk("row0_pixels", b, 8'hA5);
    chk("col0_hblank", line_hb[0], 1);
    chk("col0_video", line_vid[0], 0);
    chk("post_active_video", line_vid[HA + 64], 0);
    chk("post_active_hblank", line_hb[HA + 64], 1);
    n = 0; for (int h = 0; h < HT; h++) n += line_hs[h];
    chk("hsync_width", n, HL);
    chk("hsync_start", line_hs[HS], 1);
    n = 0; for (int v = 0; v < VT; v++) n += vs_line[v];
    chk("vsync_lines", n, VL);
    chk("vsync_start", vs_line[VS], 1);
    chk("fetches_blank_after_reset", rd_cnt[0], 0);
    chk("fetches_full_frame", rd_cnt[1], 1024);
    chk("last_fetch_addr", last_addr1, 1023);
    chk("fetches_edge_lines", edge_fetch, 0);
    chk("fetches_disabled_frame", rd_cnt[2], 0);
    chk("fetches_resumed_frame", rd_cnt[3], 72);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
